// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes over a 128-bit state, LANES inverse S-box lookups per cycle.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] IN_DATA,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] ISB_DATA,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [127:0]   in_reg;
  logic [127:0]   isb;
  logic           last_chunk;
  logic [6:0]     lane_pos [LANES];
  logic [7:0]     lane_out [LANES];

  assign last_chunk = (cnt == CW'(N - 1));
  assign ISB_DATA   = isb;

  // Byte k lives at bit offset 8*(15-k), which is {~k, 3'b000} for a 4-bit k.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_pos[l] = {~(4'(32'(cnt) * LANES + l)), 3'b000};
      lane_out[l] = inv_sbox(in_reg[lane_pos[l] +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg <= '0;
      isb    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg <= IN_DATA;
            cnt    <= '0;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) isb[lane_pos[l] +: 8] <= lane_out[l];
          cnt <= last_chunk ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: directed and random states against a GF(2^8)-derived
// S-box model, plus round-trip instances for every legal LANES value.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] isb_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   sbox_t [256];
  logic [7:0]   inv_t  [256];
  logic [127:0] exp_q [$];
  logic         rt_go    = 1'b0;
  logic         rt_rst_n = 1'b0;
  int           rt_done  = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IN_DATA  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ISB_DATA (isb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: S-box from the GF(2^8) inverse and affine map, inverse by permutation.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x] = s;
      inv_t[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_t[st[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_t[st[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one state; returns at the falling edge after the accepting edge.
  task automatic send(input logic [127:0] d);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("timeout_in_ready", 128'(in_ready), 128'(1));
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("timeout_out_valid", 128'(out_valid), 128'(1));
  endtask

  task automatic run_one(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int lat;
    send(d);
    wait_out(lat);
    check({tag, "_data"}, isb_data, exp);
    check({tag, "_latency"}, 128'(lat), 128'(4));
    @(negedge clk);
  endtask

  // Round-trip instances for the other lane counts, each on its own handshake.
  localparam int RT_LANES [4] = '{1, 2, 8, 16};

  for (genvar g = 0; g < 4; g++) begin : g_rt
    localparam int L = RT_LANES[g];
    logic [127:0] d;
    logic [127:0] q;
    logic         iv;
    logic         ir;
    logic         ov;
    logic         bz;

    inv_sub_bytes_seq #(.LANES(L)) u_rt (
      .clk      (clk),
      .rst_n    (rt_rst_n),
      .IN_DATA  (d),
      .in_valid (iv),
      .in_ready (ir),
      .ISB_DATA (q),
      .out_valid(ov),
      .out_ready(1'b1),
      .busy     (bz)
    );

    initial begin
      logic [127:0] orig;
      int           lat;
      int           w;
      iv = 1'b0;
      d  = '0;
      wait (rt_go);
      repeat (150) begin
        @(negedge clk);
        w = 0;
        while (!ir && w < 50) begin
          @(negedge clk);
          w++;
        end
        check($sformatf("rt%0d_ready", L), 128'(ir), 128'(1));
        orig = rand128();
        d    = sub_state(orig);
        iv   = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        check($sformatf("rt%0d_busy", L), 128'(bz), 128'(1));
        lat = 0;
        while (!ov && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("rt%0d_data", L), q, orig);
        check($sformatf("rt%0d_latency", L), 128'(lat), 128'(16 / L));
      end
      rt_done++;
    end
  end

  initial begin
    logic [127:0] orig;
    logic [127:0] orig2;
    logic [127:0] v;
    logic [127:0] held;
    int           lat;
    int           w;
    int           idx;
    int           got;
    int           cyc;
    int           last_cyc;

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    build_tables();
    rt_rst_n = 1'b1;
    rt_go    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_data", isb_data, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // All 0x63 -> all 0x00, four BUSY cycles, in_ready low until back in IDLE
    out_ready = 1'b1;
    send({16{8'h63}});
    check("t1_busy", 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 100) begin
      check("t1_in_ready_low", 128'(in_ready), 128'(0));
      @(negedge clk);
      lat++;
    end
    check("t1_latency", 128'(lat), 128'(4));
    check("t1_data", isb_data, 128'(0));
    check("t1_in_ready_done", 128'(in_ready), 128'(0));
    @(negedge clk);
    check("t1_idle_out_valid", 128'(out_valid), 128'(0));
    check("t1_idle_in_ready", 128'(in_ready), 128'(1));

    // Known vectors
    run_one("t2_vec", 128'h637C777BF26B6FC53001672BFED7AB76, 128'h000102030405060708090A0B0C0D0E0F);
    v = rand128();
    v[127:104] = 24'h00ED16;
    send(v);
    wait_out(lat);
    check("t2_byte_00", 128'(isb_data[127:120]), 128'(8'h52));
    check("t2_byte_ed", 128'(isb_data[119:112]), 128'(8'h53));
    check("t2_byte_16", 128'(isb_data[111:104]), 128'(8'hFF));
    check("t2_model", isb_data, inv_state(v));
    @(negedge clk);

    // Random round trips with random downstream stalls
    repeat (40) begin
      orig = rand128();
      exp_q.push_back(orig);
      out_ready = 1'b0;
      send(sub_state(orig));
      wait_out(lat);
      check("rnd_latency", 128'(lat), 128'(4));
      held = isb_data;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rnd_hold_valid", 128'(out_valid), 128'(1));
        check("rnd_hold_data", isb_data, held);
      end
      out_ready = 1'b1;
      check("rnd_data", isb_data, exp_q.pop_front());
      @(negedge clk);
    end

    // Ten-cycle backpressure with a competing in_valid
    out_ready = 1'b0;
    orig  = rand128();
    orig2 = rand128();
    send(sub_state(orig));
    wait_out(lat);
    check("t4_data", isb_data, orig);
    repeat (10) begin
      in_valid = 1'b1;
      in_data  = rand128();
      @(negedge clk);
      check("t4_hold_valid", 128'(out_valid), 128'(1));
      check("t4_hold_data", isb_data, orig);
      check("t4_hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_data   = sub_state(orig2);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", 128'(out_valid), 128'(0));
    check("t4_release_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_second_busy", 128'(busy), 128'(1));
    wait_out(lat);
    check("t4_second_data", isb_data, orig2);
    check("t4_second_latency", 128'(lat), 128'(4));
    @(negedge clk);

    // Reset two chunks into BUSY
    send(sub_state(rand128()));
    repeat (2) @(negedge clk);
    check("t5_busy_before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 128'(out_valid), 128'(0));
    check("t5_in_ready", 128'(in_ready), 128'(1));
    check("t5_data", isb_data, 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t5_no_pulse", 128'(out_valid), 128'(0));
    end
    orig = rand128();
    run_one("t5_after", sub_state(orig), orig);

    // Back-to-back stream, one result every N+2 cycles
    out_ready = 1'b1;
    exp_q.delete();
    idx      = 0;
    got      = 0;
    cyc      = 0;
    last_cyc = 0;
    while (got < 8 && cyc < 300) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("t6_unexpected", 128'(exp_q.size()), 128'(1));
        else check("t6_data", isb_data, exp_q.pop_front());
        if (got > 0) check("t6_period", 128'(cyc - last_cyc), 128'(6));
        last_cyc = cyc;
        got++;
      end
      if (in_ready && idx < 8) begin
        orig = rand128();
        exp_q.push_back(orig);
        in_data  = sub_state(orig);
        in_valid = 1'b1;
        idx++;
      end else if (idx == 8) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("t6_count", 128'(got), 128'(8));

    w = 0;
    while (rt_done < 4 && w < 40000) begin
      @(negedge clk);
      w++;
    end
    check("rt_complete", 128'(rt_done), 128'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
